branch_predictor: RTL and testbench

Dynamic branch predictor and redirect controller for the 16-bit pipelined CPU. It sits beside the IF stage and supplies a predicted next PC every cycle from a direct-mapped BTB with a 2-bit saturating counter per entry. It also consumes the branch outcome resolved in ID (bcond from the branch resolve logic, plus target) to raise a same-cycle redirect on misprediction and update the table. It keeps saturating branch and mispredict counters for the debug port.

---
 rtl/branch_predictor.sv | 194 +++++++++++++++++++
 tb/tb_branch_predictor.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Dynamic branch predictor and redirect controller for the 16-bit pipelined CPU.
//
// This block sits beside the IF stage. Every cycle it looks up if_pc in a
// direct-mapped BTB. Each BTB entry holds a valid bit, a tag, a 16-bit target
// and a 2-bit saturating counter. The lookup supplies a predicted next PC
// with zero cycles of latency.
//
// It also takes the branch outcome resolved in ID. On a misprediction it
// raises a redirect in the same cycle, and it updates the table on the next
// rising edge.
//
// Ports:
//   clk              in   clock, all state updates on rising edge
//   reset            in   asynchronous active-high reset, clears all state
//   if_pc            in   current fetch PC
//   predict_taken    out  BTB hit with valid entry and counter[1] set
//   predicted_pc     out  BTB target when predict_taken, else if_pc+1
//   id_valid         in   ID holds a valid, non-stalled instruction
//   id_pc            in   PC of the ID instruction
//   id_is_branch     in   conditional branch
//   id_is_jump       in   unconditional transfer with known target
//   id_bcond         in   resolved branch condition
//   id_target        in   resolved target
//   id_pred_pc       in   predicted_pc carried down with the instruction
//   redirect_valid   out  misprediction: flush IF/ID and load redirect_pc
//   redirect_pc      out  correct next PC for the ID instruction
//   branch_count     out  resolved branches+jumps, saturating
//   mispredict_count out  mispredicts, saturating
module branch_predictor #(
   parameter int unsigned BTB_INDEX_BITS = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] if_pc,
   output logic        predict_taken,
   output logic [15:0] predicted_pc,
   input  logic        id_valid,
   input  logic [15:0] id_pc,
   input  logic        id_is_branch,
   input  logic        id_is_jump,
   input  logic        id_bcond,
   input  logic [15:0] id_target,
   input  logic [15:0] id_pred_pc,
   output logic        redirect_valid,
   output logic [15:0] redirect_pc,
   output logic [15:0] branch_count,
   output logic [15:0] mispredict_count
);

   localparam int unsigned Entries = 2 ** BTB_INDEX_BITS;
   localparam int unsigned TagBits = 16 - BTB_INDEX_BITS;

   // Counter encodings: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
   localparam logic [1:0] CtrStrongNt = 2'b00;
   localparam logic [1:0] CtrWeakNt   = 2'b01;
   localparam logic [1:0] CtrWeakT    = 2'b10;
   localparam logic [1:0] CtrStrongT  = 2'b11;

   // ---------------------------------------------------------------------
   // BTB storage
   // ---------------------------------------------------------------------
   logic [Entries-1:0] valid_q;
   logic [TagBits-1:0] tag_q    [Entries];
   logic [15:0]        target_q [Entries];
   logic [1:0]         ctr_q    [Entries];

   // ---------------------------------------------------------------------
   // IF-side lookup
   // ---------------------------------------------------------------------
   logic [BTB_INDEX_BITS-1:0] if_idx;
   logic [TagBits-1:0]        if_tag;
   logic                      if_hit;

   assign if_idx = if_pc[BTB_INDEX_BITS-1:0];
   assign if_tag = if_pc[15:BTB_INDEX_BITS];
   assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

   assign predict_taken = if_hit && ctr_q[if_idx][1];
   assign predicted_pc  = predict_taken ? target_q[if_idx] : if_pc + 16'd1;

   // ---------------------------------------------------------------------
   // ID-side resolution
   // ---------------------------------------------------------------------
   logic [BTB_INDEX_BITS-1:0] id_idx;
   logic [TagBits-1:0]        id_tag;
   logic                      id_hit;
   logic                      id_taken;
   logic [15:0]               id_actual;
   logic                      mispredict;
   logic                      is_control;

   assign id_idx     = id_pc[BTB_INDEX_BITS-1:0];
   assign id_tag     = id_pc[15:BTB_INDEX_BITS];
   assign id_hit     = valid_q[id_idx] && (tag_q[id_idx] == id_tag);
   assign id_taken   = id_is_jump || (id_is_branch && id_bcond);
   assign id_actual  = id_taken ? id_target : id_pc + 16'd1;
   // Also covers plain instructions that were steered by an aliasing hit.
   assign mispredict = id_valid && (id_pred_pc != id_actual);
   assign is_control = id_is_branch || id_is_jump;

   assign redirect_valid = mispredict && !reset;
   assign redirect_pc    = id_actual;

   // ---------------------------------------------------------------------
   // Next contents of the entry addressed by id_pc
   // ---------------------------------------------------------------------
   logic               wr_en;
   logic               wr_valid;
   logic [TagBits-1:0] wr_tag;
   logic [15:0]        wr_target;
   logic [1:0]         wr_ctr;

   always_comb begin
      wr_en     = 1'b0;
      wr_valid  = valid_q[id_idx];
      wr_tag    = tag_q[id_idx];
      wr_target = target_q[id_idx];
      wr_ctr    = ctr_q[id_idx];

      if (id_valid) begin
         if (id_is_jump) begin
            // Jumps win over branches when both flags are set.
            wr_en     = 1'b1;
            wr_valid  = 1'b1;
            wr_tag    = id_tag;
            wr_target = id_target;
            wr_ctr    = CtrStrongT;
         end else if (id_is_branch) begin
            if (id_hit) begin
               wr_en = 1'b1;
               if (id_bcond) begin
                  wr_target = id_target;
                  if (ctr_q[id_idx] != CtrStrongT) begin
                     wr_ctr = ctr_q[id_idx] + 2'd1;
                  end
               end else if (ctr_q[id_idx] != CtrStrongNt) begin
                  wr_ctr = ctr_q[id_idx] - 2'd1;
               end
            end else if (id_bcond) begin
               wr_en     = 1'b1;
               wr_valid  = 1'b1;
               wr_tag    = id_tag;
               wr_target = id_target;
               wr_ctr    = CtrWeakT;
            end
         end else if (id_hit) begin
            // A plain instruction hit the BTB. Drop the stale entry so the
            // alias stops steering fetch.
            wr_en    = 1'b1;
            wr_valid = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         for (int i = 0; i < Entries; i++) begin
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= CtrWeakNt;
         end
      end else if (wr_en) begin
         valid_q[id_idx]  <= wr_valid;
         tag_q[id_idx]    <= wr_tag;
         target_q[id_idx] <= wr_target;
         ctr_q[id_idx]    <= wr_ctr;
      end
   end

   // ---------------------------------------------------------------------
   // Saturating statistics
   // ---------------------------------------------------------------------
   logic [15:0] branch_count_q;
   logic [15:0] mispredict_count_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         branch_count_q     <= '0;
         mispredict_count_q <= '0;
      end else begin
         if (id_valid && is_control && (branch_count_q != 16'hFFFF)) begin
            branch_count_q <= branch_count_q + 16'd1;
         end
         if (mispredict && (mispredict_count_q != 16'hFFFF)) begin
            mispredict_count_q <= mispredict_count_q + 16'd1;
         end
      end
   end

   assign branch_count     = branch_count_q;
   assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor. It keeps a table-level model of the BTB and
// the stats, checks the DUT against that model every cycle, and also checks
// a set of hand-computed values.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] if_pc;
   logic        predict_taken;
   logic [15:0] predicted_pc;
   logic        id_valid;
   logic [15:0] id_pc;
   logic        id_is_branch;
   logic        id_is_jump;
   logic        id_bcond;
   logic [15:0] id_target;
   logic [15:0] id_pred_pc;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic [15:0] branch_count;
   logic [15:0] mispredict_count;

   branch_predictor #(.BTB_INDEX_BITS(8)) dut (
      .clk              (clk),
      .reset            (reset),
      .if_pc            (if_pc),
      .predict_taken    (predict_taken),
      .predicted_pc     (predicted_pc),
      .id_valid         (id_valid),
      .id_pc            (id_pc),
      .id_is_branch     (id_is_branch),
      .id_is_jump       (id_is_jump),
      .id_bcond         (id_bcond),
      .id_target        (id_target),
      .id_pred_pc       (id_pred_pc),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .branch_count     (branch_count),
      .mispredict_count (mispredict_count)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Behavioural model: 256 entries, counter held as an integer 0..3.
   // ------------------------------------------------------------------
   bit          m_valid [256];
   logic [7:0]  m_tag   [256];
   logic [15:0] m_tgt   [256];
   int          m_ctr   [256];
   int          m_bc;
   int          m_mc;

   function automatic bit m_taken_pred(input logic [15:0] pc);
      int idx = int'(pc[7:0]);
      return m_valid[idx] && (m_tag[idx] == pc[15:8]) && (m_ctr[idx] >= 2);
   endfunction

   function automatic logic [15:0] m_pred(input logic [15:0] pc);
      if (m_taken_pred(pc)) return m_tgt[int'(pc[7:0])];
      return pc + 16'd1;
   endfunction

   function automatic logic [15:0] m_actual();
      if (id_is_jump || (id_is_branch && id_bcond)) return id_target;
      return id_pc + 16'd1;
   endfunction

   function automatic bit m_misp();
      return id_valid && (id_pred_pc != m_actual());
   endfunction

   always @(posedge clk or posedge reset) begin : model
      int idx;
      bit hit;
      if (reset) begin
         for (int i = 0; i < 256; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
         end
         m_bc = 0;
         m_mc = 0;
      end else if (id_valid) begin
         idx = int'(id_pc[7:0]);
         hit = m_valid[idx] && (m_tag[idx] == id_pc[15:8]);
         if (m_misp() && m_mc < 65535) m_mc = m_mc + 1;
         if ((id_is_branch || id_is_jump) && m_bc < 65535) m_bc = m_bc + 1;
         if (id_is_jump) begin
            m_valid[idx] = 1'b1; m_tag[idx] = id_pc[15:8]; m_tgt[idx] = id_target;
            m_ctr[idx] = 3;
         end else if (id_is_branch) begin
            if (hit) begin
               if (id_bcond) begin
                  m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
                  m_tgt[idx] = id_target;
               end else begin
                  m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
               end
            end else if (id_bcond) begin
               m_valid[idx] = 1'b1; m_tag[idx] = id_pc[15:8]; m_tgt[idx] = id_target;
               m_ctr[idx] = 2;
            end
         end else if (hit) begin
            m_valid[idx] = 1'b0;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      check("predict_taken", {15'd0, predict_taken}, {15'd0, m_taken_pred(if_pc)});
      check("predicted_pc", predicted_pc, m_pred(if_pc));
      check("redirect_valid", {15'd0, redirect_valid}, {15'd0, m_misp() && !reset});
      if (m_misp() && !reset) check("redirect_pc", redirect_pc, m_actual());
      check("branch_count", branch_count, 16'(m_bc));
      check("mispredict_count", mispredict_count, 16'(m_mc));
   end

   // ------------------------------------------------------------------
   // Directed stimulus
   // ------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic id_drive(input logic [15:0] pc, input logic br, input logic jmp,
                           input logic bc, input logic [15:0] tgt, input logic [15:0] pred);
      id_valid     = 1'b1;
      id_pc        = pc;
      id_is_branch = br;
      id_is_jump   = jmp;
      id_bcond     = bc;
      id_target    = tgt;
      id_pred_pc   = pred;
   endtask

   task automatic id_idle();
      id_valid     = 1'b0;
      id_is_branch = 1'b0;
      id_is_jump   = 1'b0;
   endtask

   logic [15:0] preds [4];

   initial begin
      reset = 1'b1;
      if_pc = 16'h0010;
      id_valid = 1'b0; id_pc = '0; id_is_branch = 1'b0; id_is_jump = 1'b0;
      id_bcond = 1'b0; id_target = '0; id_pred_pc = '0;
      #12;
      reset = 1'b0;
      #1;
      check("reset predict_taken", {15'd0, predict_taken}, 16'd0);
      check("reset predicted_pc", predicted_pc, 16'h0011);
      check("reset branch_count", branch_count, 16'd0);
      check("reset mispredict_count", mispredict_count, 16'd0);

      // First taken BEQ allocates with ctr=10.
      tick();
      id_drive(16'h0010, 1'b1, 1'b0, 1'b1, 16'h0040, 16'h0011);
      #1;
      check("beq redirect_valid", {15'd0, redirect_valid}, 16'd1);
      check("beq redirect_pc", redirect_pc, 16'h0040);
      tick();
      id_idle();
      #1;
      check("beq then predict_taken", {15'd0, predict_taken}, 16'd1);
      check("beq then predicted_pc", predicted_pc, 16'h0040);
      check("beq branch_count", branch_count, 16'd1);
      check("beq mispredict_count", mispredict_count, 16'd1);

      // Not taken from ctr=10: 10 -> 01.
      id_drive(16'h0010, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0040);
      #1;
      check("nt1 redirect_pc", redirect_pc, 16'h0011);
      tick();
      id_idle();
      #1;
      check("nt1 predict_taken", {15'd0, predict_taken}, 16'd0);
      // 01 -> 00, correctly predicted.
      id_drive(16'h0010, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0011);
      #1;
      check("nt2 redirect_valid", {15'd0, redirect_valid}, 16'd0);
      tick();

      // Four taken from 00: 01, 10, 11, 11.
      preds[0] = 16'h0011; preds[1] = 16'h0011; preds[2] = 16'h0040; preds[3] = 16'h0040;
      for (int i = 0; i < 4; i++) begin
         id_drive(16'h0010, 1'b1, 1'b0, 1'b1, 16'h0040, preds[i]);
         tick();
      end
      id_idle();
      #1;
      check("sat taken predict", {15'd0, predict_taken}, 16'd1);
      // One not-taken from 11 still predicts taken (11 -> 10).
      id_drive(16'h0010, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0040);
      tick();
      id_idle();
      #1;
      check("strong-T hysteresis", {15'd0, predict_taken}, 16'd1);

      // Aliasing: JMP at 0x0110 replaces index 0x10 with tag 0x01.
      id_drive(16'h0110, 1'b0, 1'b1, 1'b0, 16'h0200, 16'h0111);
      #1;
      check("jmp redirect_pc", redirect_pc, 16'h0200);
      tick();
      id_idle();
      #1;
      check("alias tag miss", predicted_pc, 16'h0011);
      if_pc = 16'h0110;
      #1;
      check("jmp predicted", predicted_pc, 16'h0200);
      id_drive(16'h0110, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0200);
      #1;
      check("alias redirect_valid", {15'd0, redirect_valid}, 16'd1);
      check("alias redirect_pc", redirect_pc, 16'h0111);
      tick();
      id_idle();
      #1;
      check("alias invalidated", predicted_pc, 16'h0111);

      // Branch and jump both set: behaves as a jump.
      id_drive(16'h0020, 1'b1, 1'b1, 1'b0, 16'h0300, 16'h0021);
      #1;
      check("both redirect_pc", redirect_pc, 16'h0300);
      tick();
      id_idle();
      if_pc = 16'h0020;
      #1;
      check("both predicted", predicted_pc, 16'h0300);

      // Wrap-around fall-through.
      if_pc = 16'hFFFF;
      #1;
      check("wrap predicted", predicted_pc, 16'h0000);
      id_drive(16'hFFFF, 1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000);
      #1;
      check("wrap redirect_valid", {15'd0, redirect_valid}, 16'd0);
      tick();
      id_idle();

      // Same-index read and write: IF sees pre-edge contents.
      if_pc = 16'h0030;
      id_drive(16'h0030, 1'b1, 1'b0, 1'b1, 16'h0400, 16'h0031);
      #1;
      check("no bypass", {15'd0, predict_taken}, 16'd0);
      tick();
      id_idle();
      #1;
      check("post-write predict", {15'd0, predict_taken}, 16'd1);
      check("branch_count total", branch_count, 16'd12);
      check("mispredict_count total", mispredict_count, 16'd9);

      // Saturate the mispredict counter with plain-instruction mispredicts.
      for (int i = 0; i < 65540; i++) begin
         id_drive(16'h0500, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
         tick();
      end
      id_idle();
      #1;
      check("mispredict saturated", mispredict_count, 16'hFFFF);
      check("branch_count unchanged", branch_count, 16'd12);

      // Reset between edges with an update in flight.
      tick();
      if_pc = 16'h0040;
      id_drive(16'h0040, 1'b1, 1'b0, 1'b1, 16'h0500, 16'h0041);
      #1;
      if_pc = 16'h0030;
      reset = 1'b1;
      #1;
      check("async reset mc", mispredict_count, 16'd0);
      check("async reset bc", branch_count, 16'd0);
      check("async reset predict", {15'd0, predict_taken}, 16'd0);
      check("reset blocks redirect", {15'd0, redirect_valid}, 16'd0);
      tick();
      reset = 1'b0;
      id_idle();
      if_pc = 16'h0040;
      #1;
      check("dropped update", {15'd0, predict_taken}, 16'd0);
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
